// File: rtl/mtsp_ext_mem_queue.sv
// Memory-request issue stage: DEPTH-entry op FIFO feeding a burst expander.
// Reads expand to LEN+1 beats with striding address and register index.
module mtsp_ext_mem_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int GPR_W  = 6,
    parameter int LEN_W  = 3,
    parameter int DEPTH  = 4,
    parameter int STRIDE = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       FLUSH,
    input  logic                       IN_nEN,
    output logic                       IN_READY,
    input  logic                       IN_WRITE,
    input  logic [ADDR_W-1:0]          IN_ADDR,
    input  logic [LEN_W-1:0]           IN_LEN,
    input  logic [GPR_W-1:0]           IN_SRC,
    input  logic [DATA_W-1:0]          IN_DATA,
    output logic                       MEM_nEN,
    input  logic                       MEM_READY,
    output logic                       MEM_WRITE,
    output logic [ADDR_W-1:0]          MEM_ADDR,
    output logic [GPR_W-1:0]           MEM_SRC,
    output logic [DATA_W-1:0]          MEM_DATA,
    output logic                       MEM_LAST,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       ERR_OVF
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LEN_W-1:0]  beat;
    logic [LEN_W-1:0]  len;

    logic              q_write [DEPTH];
    logic [ADDR_W-1:0] q_addr  [DEPTH];
    logic [LEN_W-1:0]  q_len   [DEPTH];
    logic [GPR_W-1:0]  q_src   [DEPTH];
    logic [DATA_W-1:0] q_data  [DEPTH];

    logic xfer;
    logic accept;
    logic pop;

    // Ready depends only on the registered count, never on this cycle's pop.
    assign IN_READY = (count < CW'(DEPTH));
    assign LEVEL    = count;
    assign xfer     = !MEM_nEN && MEM_READY;
    assign accept   = !IN_nEN && IN_READY && !FLUSH;
    // Pop when idle, or on the final beat so the next op follows without a bubble.
    assign pop      = !FLUSH && (count != '0) &&
                      ((state == IDLE) || (xfer && MEM_LAST));

    // FIFO storage; writes carry no length and reads carry no data.
    always_ff @(posedge CLK) begin
        if (accept) begin
            q_write[wr_ptr] <= IN_WRITE;
            q_addr[wr_ptr]  <= IN_ADDR;
            q_len[wr_ptr]   <= IN_WRITE ? '0 : IN_LEN;
            q_src[wr_ptr]   <= IN_SRC;
            q_data[wr_ptr]  <= IN_WRITE ? IN_DATA : '0;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ERR_OVF <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ERR_OVF <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (!accept && pop)
                count <= count - CW'(1);
            if (!IN_nEN && !IN_READY)
                ERR_OVF <= 1'b1;
        end
    end

    // Issue FSM: loads the head op, then steps beats on each transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            MEM_nEN   <= 1'b1;
            MEM_WRITE <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_SRC   <= '0;
            MEM_DATA  <= '0;
            MEM_LAST  <= 1'b0;
            beat      <= '0;
            len       <= '0;
        end else if (FLUSH) begin
            state    <= IDLE;
            MEM_nEN  <= 1'b1;
            MEM_LAST <= 1'b0;
        end else if (pop) begin
            state     <= BURST;
            MEM_nEN   <= 1'b0;
            MEM_WRITE <= q_write[rd_ptr];
            MEM_ADDR  <= q_addr[rd_ptr];
            MEM_SRC   <= q_src[rd_ptr];
            MEM_DATA  <= q_data[rd_ptr];
            len       <= q_len[rd_ptr];
            beat      <= '0;
            MEM_LAST  <= (q_len[rd_ptr] == '0);
        end else if (xfer) begin
            if (MEM_LAST) begin
                state    <= IDLE;
                MEM_nEN  <= 1'b1;
                MEM_LAST <= 1'b0;
            end else begin
                beat     <= beat + LEN_W'(1);
                MEM_ADDR <= MEM_ADDR + ADDR_W'(STRIDE);
                MEM_SRC  <= MEM_SRC + GPR_W'(1);
                MEM_LAST <= ((beat + LEN_W'(1)) == len);
            end
        end
    end

endmodule

// File: tb/tb_mtsp_ext_mem_queue.sv
// Directed bench for mtsp_ext_mem_queue.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mtsp_ext_mem_queue;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         FLUSH;
    logic         IN_nEN;
    logic         IN_READY;
    logic         IN_WRITE;
    logic [31:0]  IN_ADDR;
    logic [2:0]   IN_LEN;
    logic [5:0]   IN_SRC;
    logic [127:0] IN_DATA;
    logic         MEM_nEN;
    logic         MEM_READY;
    logic         MEM_WRITE;
    logic [31:0]  MEM_ADDR;
    logic [5:0]   MEM_SRC;
    logic [127:0] MEM_DATA;
    logic         MEM_LAST;
    logic [2:0]   LEVEL;
    logic         ERR_OVF;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] pat;

    mtsp_ext_mem_queue dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .FLUSH     (FLUSH),
        .IN_nEN    (IN_nEN),
        .IN_READY  (IN_READY),
        .IN_WRITE  (IN_WRITE),
        .IN_ADDR   (IN_ADDR),
        .IN_LEN    (IN_LEN),
        .IN_SRC    (IN_SRC),
        .IN_DATA   (IN_DATA),
        .MEM_nEN   (MEM_nEN),
        .MEM_READY (MEM_READY),
        .MEM_WRITE (MEM_WRITE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_SRC   (MEM_SRC),
        .MEM_DATA  (MEM_DATA),
        .MEM_LAST  (MEM_LAST),
        .LEVEL     (LEVEL),
        .ERR_OVF   (ERR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input logic wr, input logic [31:0] a,
                            input logic [2:0] l, input logic [5:0] s,
                            input logic [127:0] d);
        IN_nEN   = 1'b0;
        IN_WRITE = wr;
        IN_ADDR  = a;
        IN_LEN   = l;
        IN_SRC   = s;
        IN_DATA  = d;
    endtask

    initial begin
        nRST      = 1'b0;
        FLUSH     = 1'b0;
        IN_nEN    = 1'b1;
        IN_WRITE  = 1'b0;
        IN_ADDR   = '0;
        IN_LEN    = '0;
        IN_SRC    = '0;
        IN_DATA   = '0;
        MEM_READY = 1'b1;
        pat       = {4{32'hA5A5_5A5A}};
        tick();
        tick();

        // reset state
        check("rst_nen", MEM_nEN, 1);
        check("rst_level", LEVEL, 0);
        check("rst_ovf", ERR_OVF, 0);
        check("rst_ready", IN_READY, 1);
        check("rst_last", MEM_LAST, 0);
        check("rst_addr", MEM_ADDR, 0);
        nRST = 1'b1;
        tick();

        // T1 single 4-beat read, first beat two edges after accept
        drive_op(1'b0, 32'h100, 3'd3, 6'd5, '0);
        tick();
        IN_nEN = 1'b1;
        check("t1_level_acc", LEVEL, 1);
        check("t1_nen_acc", MEM_nEN, 1);
        tick();
        check("t1_level_pop", LEVEL, 0);
        for (int i = 0; i < 4; i++) begin
            check("t1_nen", MEM_nEN, 0);
            check("t1_addr", MEM_ADDR, 32'h100 + 32'(16 * i));
            check("t1_src", MEM_SRC, 6'(5 + i));
            check("t1_last", MEM_LAST, (i == 3) ? 1 : 0);
            check("t1_write", MEM_WRITE, 0);
            tick();
        end
        check("t1_idle", MEM_nEN, 1);

        // T2 write ignores LEN
        drive_op(1'b1, 32'h400, 3'd7, 6'd9, pat);
        tick();
        IN_nEN = 1'b1;
        tick();
        check("t2_nen", MEM_nEN, 0);
        check("t2_write", MEM_WRITE, 1);
        check("t2_last", MEM_LAST, 1);
        check("t2_data", MEM_DATA, pat);
        check("t2_addr", MEM_ADDR, 32'h400);
        tick();
        check("t2_one_beat", MEM_nEN, 1);

        // T3 backpressure mid-burst
        drive_op(1'b0, 32'h200, 3'd3, 6'd10, '0);
        tick();
        IN_nEN = 1'b1;
        tick();
        tick();
        check("t3_b1_addr", MEM_ADDR, 32'h210);
        MEM_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_addr", MEM_ADDR, 32'h210);
            check("t3_hold_src", MEM_SRC, 11);
            check("t3_hold_nen", MEM_NEN_ALIAS(), 0);
        end
        MEM_READY = 1'b1;
        tick();
        check("t3_b2_addr", MEM_ADDR, 32'h220);
        check("t3_b2_src", MEM_SRC, 12);
        tick();
        check("t3_b3_addr", MEM_ADDR, 32'h230);
        check("t3_b3_last", MEM_LAST, 1);
        tick();
        check("t3_idle", MEM_nEN, 1);

        // T4 fill, overflow, then back-to-back drain
        MEM_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b0, 32'h1000 + 32'(i * 256), 3'd0, 6'(i), '0);
            tick();
            if (i == 4) begin
                check("t4_ready_full", IN_READY, 0);
                check("t4_ovf_pre", ERR_OVF, 0);
            end
        end
        IN_nEN = 1'b1;
        check("t4_level", LEVEL, 4);
        check("t4_ready", IN_READY, 0);
        check("t4_ovf", ERR_OVF, 1);
        MEM_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_drain_nen", MEM_nEN, 0);
            check("t4_drain_addr", MEM_ADDR, 32'h1000 + 32'(i * 256));
            check("t4_drain_src", MEM_SRC, 6'(i));
            check("t4_drain_last", MEM_LAST, 1);
            tick();
        end
        check("t4_drained", MEM_nEN, 1);
        check("t4_level0", LEVEL, 0);
        check("t4_ovf_sticky", ERR_OVF, 1);

        // T5 address and register wrap
        drive_op(1'b0, 32'hFFFF_FFF0, 3'd1, 6'd63, '0);
        tick();
        IN_nEN = 1'b1;
        tick();
        check("t5_b0_addr", MEM_ADDR, 32'hFFFF_FFF0);
        check("t5_b0_src", MEM_SRC, 63);
        tick();
        check("t5_b1_addr", MEM_ADDR, 32'h0);
        check("t5_b1_src", MEM_SRC, 0);
        check("t5_b1_last", MEM_LAST, 1);
        tick();

        // T6a flush on beat 1 of 4 with 2 queued, with a same-cycle request
        drive_op(1'b0, 32'h300, 3'd3, 6'd20, '0);
        tick();
        drive_op(1'b0, 32'h500, 3'd0, 6'd30, '0);
        tick();
        drive_op(1'b0, 32'h600, 3'd0, 6'd31, '0);
        tick();
        check("t6_b1_addr", MEM_ADDR, 32'h310);
        check("t6_queued", LEVEL, 2);
        drive_op(1'b0, 32'h700, 3'd0, 6'd32, '0);
        FLUSH = 1'b1;
        tick();
        FLUSH  = 1'b0;
        IN_nEN = 1'b1;
        check("t6_fl_nen", MEM_nEN, 1);
        check("t6_fl_level", LEVEL, 0);
        check("t6_fl_ovf", ERR_OVF, 0);
        check("t6_fl_last", MEM_LAST, 0);
        tick();
        check("t6_fl_dropped", MEM_nEN, 1);
        check("t6_fl_level2", LEVEL, 0);
        check("t6_fl_ovf2", ERR_OVF, 0);

        // T6b async reset mid-burst
        drive_op(1'b0, 32'h800, 3'd3, 6'd40, '0);
        tick();
        drive_op(1'b0, 32'h900, 3'd0, 6'd41, '0);
        tick();
        drive_op(1'b0, 32'hA00, 3'd0, 6'd42, '0);
        tick();
        IN_nEN = 1'b1;
        MEM_READY = 1'b0;
        check("t6_pre_addr", MEM_ADDR, 32'h810);
        check("t6_pre_level", LEVEL, 2);
        #2;
        nRST = 1'b0;
        #1;
        check("t6_rst_nen", MEM_nEN, 1);
        check("t6_rst_addr", MEM_ADDR, 0);
        check("t6_rst_src", MEM_SRC, 0);
        check("t6_rst_last", MEM_LAST, 0);
        check("t6_rst_level", LEVEL, 0);
        check("t6_rst_ready", IN_READY, 1);
        tick();
        nRST = 1'b1;
        MEM_READY = 1'b1;
        tick();
        tick();
        check("t6_post_nen", MEM_nEN, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    function automatic logic MEM_NEN_ALIAS();
        return MEM_nEN;
    endfunction

endmodule
